// File: rtl/laser_coverage_check_if.sv
// Bus bundle for laser_coverage_check: point stream, candidate centres,
// DONE strobe in; busy flag, coverage counts and valid pulse out.
interface laser_coverage_check_if;
  logic [3:0] i_x;
  logic [3:0] i_y;
  logic [3:0] i_c1x;
  logic [3:0] i_c1y;
  logic [3:0] i_c2x;
  logic [3:0] i_c2y;
  logic       i_done;
  logic       o_busy;
  logic [5:0] o_c1_cnt;
  logic [5:0] o_c2_cnt;
  logic [5:0] o_score;
  logic       o_score_valid;

  modport master (
    output i_x, i_y, i_c1x, i_c1y, i_c2x, i_c2y, i_done,
    input  o_busy, o_c1_cnt, o_c2_cnt, o_score, o_score_valid
  );

  modport slave (
    input  i_x, i_y, i_c1x, i_c1y, i_c2x, i_c2y, i_done,
    output o_busy, o_c1_cnt, o_c2_cnt, o_score, o_score_valid
  );
endinterface

// File: rtl/laser_coverage_check.sv
// Coverage scoreboard for the laser-treatment centre search.
// Captures the post-reset point stream, then on each accepted DONE scores
// the two reported centres against the stored points, one point per cycle.
//
//   state  | meaning
//   LOAD   | capturing N_PTS points after reset, DONE ignored
//   IDLE   | points held, waiting for DONE to latch centres
//   SCAN   | evaluating one stored point per edge against latched centres
//   REPORT | counts just published, SCORE_VALID high for this cycle
module laser_coverage_check #(
  parameter int N_PTS     = 40,
  parameter int RADIUS_SQ = 16
) (
  input logic                  i_clk,
  input logic                  i_rst,
  laser_coverage_check_if.slave bus
);

  typedef enum logic [1:0] {S_LOAD, S_IDLE, S_SCAN, S_REPORT} state_t;

  localparam logic [5:0] LAST_IDX = 6'(N_PTS - 1);
  localparam logic [8:0] RSQ      = 9'(RADIUS_SQ);

  state_t     r_state;
  state_t     w_next;

  logic [3:0] r_px [N_PTS];
  logic [3:0] r_py [N_PTS];
  logic [5:0] r_idx;
  logic [3:0] r_c1x, r_c1y, r_c2x, r_c2y;
  logic [5:0] r_acc1, r_acc2, r_accu;
  logic [5:0] r_c1_cnt, r_c2_cnt, r_score;

  logic       w_last;
  logic [3:0] w_px, w_py;
  logic [8:0] w_d1sq, w_d2sq;
  logic       w_in1, w_in2, w_inu;

  // Full-precision squared distance; max 15^2 + 15^2 = 450 fits in 9 bits.
  function automatic logic [8:0] dist_sq(input logic [3:0] px, input logic [3:0] py,
                                         input logic [3:0] cx, input logic [3:0] cy);
    logic [3:0] dx, dy;
    logic [7:0] sx, sy;
    dx = (px >= cx) ? (px - cx) : (cx - px);
    dy = (py >= cy) ? (py - cy) : (cy - py);
    sx = {4'd0, dx} * {4'd0, dx};
    sy = {4'd0, dy} * {4'd0, dy};
    return {1'b0, sx} + {1'b0, sy};
  endfunction

  assign w_last = (r_idx == LAST_IDX);
  assign w_px   = r_px[r_idx];
  assign w_py   = r_py[r_idx];
  assign w_d1sq = dist_sq(w_px, w_py, r_c1x, r_c1y);
  assign w_d2sq = dist_sq(w_px, w_py, r_c2x, r_c2y);
  assign w_in1  = (w_d1sq <= RSQ);
  assign w_in2  = (w_d2sq <= RSQ);
  assign w_inu  = w_in1 | w_in2;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_LOAD;
    else       r_state <= w_next;
  end

  // Next-state decode; DONE only matters in IDLE
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_LOAD:   if (w_last) w_next = S_IDLE;
      S_IDLE:   if (bus.i_done) w_next = S_SCAN;
      S_SCAN:   if (w_last) w_next = S_REPORT;
      S_REPORT: w_next = S_IDLE;
      default:  w_next = S_LOAD;
    endcase
  end

  // Outputs decoded from the registered state, counts from their holding registers
  always_comb begin
    bus.o_busy        = (r_state == S_LOAD) || (r_state == S_SCAN);
    bus.o_score_valid = (r_state == S_REPORT);
    bus.o_c1_cnt      = r_c1_cnt;
    bus.o_c2_cnt      = r_c2_cnt;
    bus.o_score       = r_score;
  end

  // Point storage; contents are don't-care until reloaded, so no reset
  always_ff @(posedge i_clk) begin
    if (r_state == S_LOAD) begin
      r_px[r_idx] <= bus.i_x;
      r_py[r_idx] <= bus.i_y;
    end
  end

  // Index, centre latch, accumulators and published counts
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_idx    <= '0;
      r_c1x    <= '0;
      r_c1y    <= '0;
      r_c2x    <= '0;
      r_c2y    <= '0;
      r_acc1   <= '0;
      r_acc2   <= '0;
      r_accu   <= '0;
      r_c1_cnt <= '0;
      r_c2_cnt <= '0;
      r_score  <= '0;
    end else begin
      case (r_state)
        S_LOAD: r_idx <= w_last ? 6'd0 : r_idx + 6'd1;
        S_IDLE: begin
          if (bus.i_done) begin
            r_c1x  <= bus.i_c1x;
            r_c1y  <= bus.i_c1y;
            r_c2x  <= bus.i_c2x;
            r_c2y  <= bus.i_c2y;
            r_acc1 <= '0;
            r_acc2 <= '0;
            r_accu <= '0;
            r_idx  <= '0;
          end
        end
        S_SCAN: begin
          r_acc1 <= r_acc1 + {5'd0, w_in1};
          r_acc2 <= r_acc2 + {5'd0, w_in2};
          r_accu <= r_accu + {5'd0, w_inu};
          r_idx  <= w_last ? 6'd0 : r_idx + 6'd1;
          // Publish including the final point so outputs change exactly on REPORT entry
          if (w_last) begin
            r_c1_cnt <= r_acc1 + {5'd0, w_in1};
            r_c2_cnt <= r_acc2 + {5'd0, w_in2};
            r_score  <= r_accu + {5'd0, w_inu};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_laser_coverage_check.sv
// Bench for laser_coverage_check: table of point patterns and centres with
// expected counts, a scoreboard queue popped on SCORE_VALID, and hand-written
// sequences for ignored DONEs, re-scoring and reset mid-scan.
module tb_laser_coverage_check;
  localparam int N = 40;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  laser_coverage_check_if bif ();

  laser_coverage_check #(.N_PTS(N), .RADIUS_SQ(16)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bif)
  );

  typedef struct {
    int pat;
    int c1x, c1y, c2x, c2y;
    int e1, e2, es;
  } vec_t;

  typedef struct {
    int e1, e2, es;
    int n;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  vec_t vt[8];
  int   px[N];
  int   py[N];
  int   ncyc    = 0;
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic void set_pattern(input int pat);
    for (int i = 0; i < N; i++) begin
      case (pat)
        0: begin px[i] = 0; py[i] = 0; end
        1: begin px[i] = 15; py[i] = 0; end
        2: begin px[i] = (i < 20) ? 5 : 15; py[i] = (i < 20) ? 5 : 15; end
        3: begin px[i] = (i * 7 + 3) % 16; py[i] = (i * 5 + 1) % 16; end
        default: begin px[i] = (i * 3) % 16; py[i] = (i * 11 + 2) % 16; end
      endcase
    end
    if (pat == 1) begin
      px[0] = 4; py[0] = 0;
      px[1] = 0; py[1] = 4;
      px[2] = 2; py[2] = 2;
      px[3] = 3; py[3] = 3;
      px[4] = 5; py[4] = 0;
    end
  endfunction

  function automatic void model(input int c1x, input int c1y, input int c2x, input int c2y,
                                output int e1, output int e2, output int es);
    int d1, d2;
    e1 = 0; e2 = 0; es = 0;
    for (int i = 0; i < N; i++) begin
      d1 = (px[i] - c1x) * (px[i] - c1x) + (py[i] - c1y) * (py[i] - c1y);
      d2 = (px[i] - c2x) * (px[i] - c2x) + (py[i] - c2y) * (py[i] - c2y);
      if (d1 <= 16) e1++;
      if (d2 <= 16) e2++;
      if (d1 <= 16 || d2 <= 16) es++;
    end
  endfunction

  // Scoreboard monitor: every SCORE_VALID must match the oldest accepted DONE
  always @(negedge clk) begin
    ncyc = ncyc + 1;
    if (bif.o_score_valid === 1'b1) begin
      if (sbq.size() == 0) begin
        check("unexpected_valid", int'(bif.o_score_valid), 0);
      end else begin
        mon_e = sbq.pop_front();
        check("c1_cnt", int'(bif.o_c1_cnt), mon_e.e1);
        check("c2_cnt", int'(bif.o_c2_cnt), mon_e.e2);
        check("score", int'(bif.o_score), mon_e.es);
        check("latency", ncyc - mon_e.n, N + 1);
        check("busy_report", int'(bif.o_busy), 0);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic load_points(input bit done_during);
    for (int k = 0; k < N; k++) begin
      bif.i_x = px[k][3:0];
      bif.i_y = py[k][3:0];
      if (done_during && k == 10) begin
        bif.i_done = 1'b1;
        bif.i_c1x = 4'd0; bif.i_c1y = 4'd0; bif.i_c2x = 4'd0; bif.i_c2y = 4'd0;
      end else begin
        bif.i_done = 1'b0;
      end
      if (k == 20) check("busy_load", int'(bif.o_busy), 1);
      tick();
    end
    bif.i_done = 1'b0;
    check("busy_idle", int'(bif.o_busy), 0);
  endtask

  task automatic reset_and_load(input bit done_during);
    rst = 1'b1;
    bif.i_done = 1'b0;
    tick();
    check("rst_c1", int'(bif.o_c1_cnt), 0);
    check("rst_c2", int'(bif.o_c2_cnt), 0);
    check("rst_score", int'(bif.o_score), 0);
    check("rst_valid", int'(bif.o_score_valid), 0);
    check("rst_busy", int'(bif.o_busy), 1);
    rst = 1'b0;
    load_points(done_during);
  endtask

  task automatic start_done(input int c1x, input int c1y, input int c2x, input int c2y,
                            input int e1, input int e2, input int es, input bit push);
    exp_t e;
    bif.i_c1x = 4'(c1x); bif.i_c1y = 4'(c1y);
    bif.i_c2x = 4'(c2x); bif.i_c2y = 4'(c2y);
    bif.i_done = 1'b1;
    if (push) begin
      e.e1 = e1; e.e2 = e2; e.es = es; e.n = ncyc;
      sbq.push_back(e);
    end
    tick();
    bif.i_done = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < N + 10 && sbq.size() != 0; i++) tick();
    if (sbq.size() != 0) begin
      check("drain_timeout", sbq.size(), 0);
      sbq.delete();
    end
    repeat (3) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e1, e2, es;
    rst = 1'b1;
    bif.i_x = '0; bif.i_y = '0; bif.i_done = 1'b0;
    bif.i_c1x = '0; bif.i_c1y = '0; bif.i_c2x = '0; bif.i_c2y = '0;

    vt[0] = '{0, 0, 0, 15, 15, 40, 0, 40};
    vt[1] = '{1, 0, 0, 8, 8, 3, 0, 3};
    vt[2] = '{2, 4, 4, 6, 6, 20, 20, 20};
    vt[3] = '{0, 15, 15, 0, 0, 0, 40, 40};
    vt[4] = '{0, 3, 3, 3, 3, 0, 0, 0};
    vt[5] = '{0, 4, 0, 0, 4, 40, 40, 40};
    vt[6] = '{3, 7, 7, 12, 3, -1, -1, -1};
    vt[7] = '{4, 0, 15, 9, 9, -1, -1, -1};

    tick();
    for (int i = 0; i < 8; i++) begin
      set_pattern(vt[i].pat);
      reset_and_load(i == 0);
      if (vt[i].e1 < 0) model(vt[i].c1x, vt[i].c1y, vt[i].c2x, vt[i].c2y, e1, e2, es);
      else begin e1 = vt[i].e1; e2 = vt[i].e2; es = vt[i].es; end
      start_done(vt[i].c1x, vt[i].c1y, vt[i].c2x, vt[i].c2y, e1, e2, es, 1'b1);
      wait_drain();
    end

    // DONE and centre changes during SCAN are ignored
    set_pattern(2);
    reset_and_load(1'b0);
    start_done(4, 4, 6, 6, 20, 20, 20, 1'b1);
    repeat (10) tick();
    for (int k = 0; k < 6; k++) begin
      bif.i_done = 1'b1;
      bif.i_c1x = 4'($urandom_range(0, 15)); bif.i_c1y = 4'($urandom_range(0, 15));
      bif.i_c2x = 4'($urandom_range(0, 15)); bif.i_c2y = 4'($urandom_range(0, 15));
      tick();
    end
    bif.i_done = 1'b0;
    check("busy_scan", int'(bif.o_busy), 1);
    wait_drain();

    // Re-score retained points; a DONE in the REPORT cycle is dropped
    start_done(5, 5, 15, 15, 20, 20, 40, 1'b1);
    repeat (40) tick();
    check("valid_in_report", int'(bif.o_score_valid), 1);
    bif.i_c1x = 4'd0; bif.i_c1y = 4'd0; bif.i_c2x = 4'd0; bif.i_c2y = 4'd0;
    bif.i_done = 1'b1;
    tick();
    bif.i_done = 1'b0;
    repeat (N + 5) tick();
    start_done(15, 15, 0, 0, 20, 0, 20, 1'b1);
    wait_drain();

    // Reset in the middle of a scan: no report, cleared outputs, full reload
    start_done(4, 4, 6, 6, 0, 0, 0, 1'b0);
    repeat (20) tick();
    rst = 1'b1;
    tick();
    check("abort_c1", int'(bif.o_c1_cnt), 0);
    check("abort_c2", int'(bif.o_c2_cnt), 0);
    check("abort_score", int'(bif.o_score), 0);
    check("abort_valid", int'(bif.o_score_valid), 0);
    check("abort_busy", int'(bif.o_busy), 1);
    rst = 1'b0;
    set_pattern(3);
    load_points(1'b0);
    repeat (5) tick();
    model(2, 9, 10, 4, e1, e2, es);
    start_done(2, 9, 10, 4, e1, e2, es, 1'b1);
    wait_drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
